// File: rtl/round_robin_arbiter_if.sv
// rtl/round_robin_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Signals
//   req          requesters -> arbiter  WIDTH  per-requester request level
//   release_in   requesters -> arbiter  1      current owner is done with the resource
//   flush        requesters -> arbiter  1      drop the current grant without a release
//   grant        arbiter -> requesters  WIDTH  one-hot registered grant, zero when idle
//   grant_index  arbiter -> requesters  IW     binary index of grant, zero when idle
//   grant_valid  arbiter -> requesters  1      |grant
//   busy         arbiter -> requesters  1      resource is owned
// Modports
//   master  requester side (drives req/release_in/flush)
//   slave   arbiter side (drives grant/grant_index/grant_valid/busy)

interface round_robin_arbiter_if #(
    parameter int WIDTH = 4
);
    // Index width; collapses to a single bit for a one-requester lock.
    localparam int IW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] req;
    logic             release_in;
    logic             flush;
    logic [WIDTH-1:0] grant;
    logic [IW-1:0]    grant_index;
    logic             grant_valid;
    logic             busy;

    modport master (
        output req,
        output release_in,
        output flush,
        input  grant,
        input  grant_index,
        input  grant_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  release_in,
        input  flush,
        output grant,
        output grant_index,
        output grant_valid,
        output busy
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - sticky round-robin arbiter granting one shared resource to WIDTH requesters
//
// Parameters
//   WIDTH  number of requesters, power of two, >= 1
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous reset, active-high
//   bus    round_robin_arbiter_if.slave: req/release_in/flush in, grant/grant_index/grant_valid/busy out
//
// A grant, once awarded, is held until the owner pulses release_in or flush
// drops it. The priority pointer always points one past the most recent
// winner, so the previous owner is searched last on the next arbitration.

module round_robin_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    round_robin_arbiter_if.slave bus
);
    localparam int IW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] grant_q;
    logic [WIDTH-1:0] grant_d;
    logic [IW-1:0]    index_q;
    logic [IW-1:0]    index_d;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;

    logic             any_req;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    win_next;
    logic [IW-1:0]    cand;
    logic             award;
    logic             drop;

    assign any_req = |bus.req;

    // Winner search: walk ptr, ptr+1, ... modulo WIDTH and take the first
    // requester found. The modulo keeps WIDTH==1 pinned to index 0 even
    // though the index is one bit wide there.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand = IW'((int'(ptr_q) + i) % WIDTH);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_next = IW'((int'(win_idx) + 1) % WIDTH);

    // Event decode shared by next-state and output logic. flush outranks
    // release_in, and release_in in IDLE is simply ignored.
    assign award = !bus.flush && any_req &&
                   ((state_q == IDLE) || bus.release_in);
    assign drop  = bus.flush ||
                   ((state_q == BUSY) && bus.release_in && !any_req);

    // State register together with the grant/pointer datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (award) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (drop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next grant, index and pointer. Back-to-back re-arbitration
    // on release loads the new winner in the same edge, with no idle bubble.
    always_comb begin
        grant_d = grant_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        if (drop) begin
            grant_d = '0;
            index_d = '0;
        end else if (award) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            index_d          = win_idx;
            ptr_d            = win_next;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_index = index_q;
    assign bus.grant_valid = |grant_q;
    assign bus.busy        = (state_q == BUSY);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - directed and randomized self-checking bench for round_robin_arbiter

module tb_round_robin_arbiter;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    round_robin_arbiter_if #(.WIDTH(WIDTH)) bus ();

    round_robin_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource and where the search starts.
    bit m_valid;
    int m_owner;
    int m_ptr;
    int wait_cnt [WIDTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic [WIDTH-1:0] r, input bit rel, input bit fl, input bit rs);
        bit arbitrate;
        int winner;
        if (rs) begin
            m_valid = 0;
            m_owner = 0;
            m_ptr   = 0;
            foreach (wait_cnt[i]) wait_cnt[i] = 0;
            return;
        end
        for (int i = 0; i < WIDTH; i++) if (!r[i]) wait_cnt[i] = 0;
        if (fl) begin
            m_valid = 0;
            return;
        end
        arbitrate = (!m_valid && r != 0) || (m_valid && rel);
        if (!arbitrate) return;
        winner = -1;
        for (int k = 0; k < WIDTH; k++) begin
            int j;
            j = (m_ptr + k) % WIDTH;
            if (winner < 0 && r[j]) winner = j;
        end
        if (winner < 0) begin
            m_valid = 0;
        end else begin
            m_valid = 1;
            m_owner = winner;
            m_ptr   = (winner + 1) % WIDTH;
            for (int i = 0; i < WIDTH; i++) begin
                if (i == winner) wait_cnt[i] = 0;
                else if (r[i]) wait_cnt[i]++;
            end
        end
    endtask

    // One clock: capture inputs, advance model at the edge, compare 1 ns later.
    task automatic step();
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] prev_grant;
        bit rel, fl, rs;
        int worst;
        logic [WIDTH-1:0] exp_grant;
        r          = bus.req;
        rel        = bus.release_in;
        fl         = bus.flush;
        rs         = rst;
        prev_grant = bus.grant;
        @(posedge clk);
        model_update(r, rel, fl, rs);
        #1;
        exp_grant = m_valid ? WIDTH'(1 << m_owner) : '0;
        check_eq("grant", 32'(bus.grant), 32'(exp_grant));
        check_eq("grant_index", 32'(bus.grant_index), m_valid ? 32'(m_owner) : 32'd0);
        check_eq("grant_valid", 32'(bus.grant_valid), 32'(m_valid));
        check_eq("busy", 32'(bus.busy), 32'(m_valid));
        check_eq("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        if (!rel && !fl && !rs && prev_grant != 0)
            check_eq("sticky", 32'(bus.grant), 32'(prev_grant));
        worst = 0;
        foreach (wait_cnt[i]) if (wait_cnt[i] > worst) worst = wait_cnt[i];
        check_eq("starve", 32'(worst <= WIDTH - 1), 32'd1);
    endtask

    task automatic drive(input logic [WIDTH-1:0] r, input bit rel, input bit fl, input bit rs);
        bus.req        = r;
        bus.release_in = rel;
        bus.flush      = fl;
        rst            = rs;
    endtask

    initial begin
        drive('0, 0, 0, 1);
        step();
        step();
        check_eq("reset_grant", 32'(bus.grant), 32'd0);
        check_eq("reset_valid", 32'(bus.grant_valid), 32'd0);
        check_eq("reset_busy", 32'(bus.busy), 32'd0);

        // First grant: ptr 0, req 1010 -> requester 1.
        drive(4'b1010, 0, 0, 0);
        step();
        check_eq("first_grant", 32'(bus.grant), 32'b0010);
        check_eq("first_index", 32'(bus.grant_index), 32'd1);

        // Rotation with everyone requesting, from a fresh pointer.
        drive(4'b1111, 0, 0, 1);
        step();
        drive(4'b1111, 0, 0, 0);
        step();
        check_eq("rot0", 32'(bus.grant), 32'b0001);
        drive(4'b1111, 1, 0, 0);
        step();
        check_eq("rot1", 32'(bus.grant), 32'b0010);
        step();
        check_eq("rot2", 32'(bus.grant), 32'b0100);
        step();
        check_eq("rot3", 32'(bus.grant), 32'b1000);
        step();
        check_eq("rot4", 32'(bus.grant), 32'b0001);

        // Owner 2 holds while requests vanish, then releases into IDLE.
        drive(4'b0100, 1, 0, 0);
        step();
        check_eq("own2", 32'(bus.grant), 32'b0100);
        drive(4'b0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold2", 32'(bus.grant), 32'b0100);
        end
        drive(4'b0000, 1, 0, 0);
        step();
        check_eq("rel_idle", 32'(bus.grant), 32'd0);
        check_eq("rel_idle_busy", 32'(bus.busy), 32'd0);

        // Owner 3 with ptr wrapped to 0, release with 1001 -> requester 0.
        drive(4'b1000, 0, 0, 1);
        step();
        drive(4'b1000, 0, 0, 0);
        step();
        check_eq("own3", 32'(bus.grant), 32'b1000);
        drive(4'b1001, 1, 0, 0);
        step();
        check_eq("wrap", 32'(bus.grant), 32'b0001);
        drive(4'b1111, 1, 0, 0);
        step();
        check_eq("ptr1", 32'(bus.grant), 32'b0010);

        // flush beats release; pending requests wait one bubble, ptr kept at 2.
        drive(4'b1111, 1, 1, 0);
        step();
        check_eq("flush_grant", 32'(bus.grant), 32'd0);
        drive(4'b1111, 0, 0, 0);
        step();
        check_eq("after_flush", 32'(bus.grant), 32'b0100);

        // Reset while busy.
        drive(4'b1111, 0, 0, 1);
        step();
        check_eq("rst_busy", 32'(bus.grant), 32'd0);
        drive(4'b1111, 0, 0, 0);
        step();
        check_eq("after_rst", 32'(bus.grant), 32'b0001);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(WIDTH'($urandom), ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 99) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
